// File: rtl/reg_write_arbiter.sv
// Two-source register-file writeback arbiter: per-source FIFOs, round-robin drain, registered write stage.
// Optional REGWB_ZERO_REG_EN hardwires register 0 to zero (such writes are accepted and dropped).
module reg_write_arbiter #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   ALU_VALID,
  input  logic [ADDR_W-1:0]      ALU_ADDR,
  input  logic [DATA_W-1:0]      ALU_DATA,
  output logic                   ALU_READY,
  input  logic                   MEM_VALID,
  input  logic [ADDR_W-1:0]      MEM_ADDR,
  input  logic [DATA_W-1:0]      MEM_DATA,
  output logic                   MEM_READY,
  output logic                   WRITE,
  output logic [ADDR_W-1:0]      INADDRESS,
  output logic [DATA_W-1:0]      IN,
  output logic [(2**ADDR_W)-1:0] BUSY
);

  localparam int NREG = 2**ADDR_W;
  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  typedef enum logic {SRC_ALU = 1'b0, SRC_MEM = 1'b1} src_e;

  // Index 0 is the ALU source, index 1 the MEM (load) source.
  entry_t          fifo_q [2][DEPTH];
  logic [PW-1:0]   wptr_q [2];
  logic [PW-1:0]   rptr_q [2];
  logic [CW-1:0]   cnt_q  [2];
  src_e            rr_q, rr_d;

  logic              write_q, write_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  entry_t     in_ent [2];
  entry_t     head   [2];
  entry_t     sel;
  logic [1:0] valid_in, ready, push, enq, nonempty, pop;
  logic [NREG-1:0] busy_d;

  assign in_ent[0] = '{addr: ALU_ADDR, data: ALU_DATA};
  assign in_ent[1] = '{addr: MEM_ADDR, data: MEM_DATA};
  assign valid_in  = {MEM_VALID, ALU_VALID};

  always_comb begin
    for (int r = 0; r < 2; r++) begin
      // READY looks only at current occupancy, so a full FIFO refuses even while popping.
      ready[r]    = RESET && (cnt_q[r] != FULL_CNT);
      push[r]     = valid_in[r] && ready[r];
`ifdef REGWB_ZERO_REG_EN
      enq[r]      = push[r] && (in_ent[r].addr != '0);
`else
      enq[r]      = push[r];
`endif
      nonempty[r] = (cnt_q[r] != '0);
      head[r]     = fifo_q[r][rptr_q[r]];
    end
  end

  // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
  always_comb begin
    pop  = 2'b00;
    rr_d = rr_q;
    if (nonempty[0] && nonempty[1]) begin
      if (head[0].addr == head[1].addr) begin
        pop[1] = 1'b1;
        rr_d   = SRC_ALU;
      end else if (rr_q == SRC_ALU) begin
        pop[0] = 1'b1;
        rr_d   = SRC_MEM;
      end else begin
        pop[1] = 1'b1;
        rr_d   = SRC_ALU;
      end
    end else if (nonempty[0]) begin
      pop[0] = 1'b1;
    end else if (nonempty[1]) begin
      pop[1] = 1'b1;
    end
  end

  always_comb begin
    sel     = pop[1] ? head[1] : head[0];
    write_d = |pop;
    waddr_d = write_d ? sel.addr : waddr_q;
    wdata_d = write_d ? sel.data : wdata_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int r = 0; r < 2; r++) begin
        wptr_q[r] <= '0;
        rptr_q[r] <= '0;
        cnt_q[r]  <= '0;
      end
      rr_q    <= SRC_ALU;
      write_q <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      for (int r = 0; r < 2; r++) begin
        if (enq[r]) wptr_q[r] <= wptr_q[r] + PW'(1);
        if (pop[r]) rptr_q[r] <= rptr_q[r] + PW'(1);
        cnt_q[r] <= cnt_q[r] + CW'(enq[r]) - CW'(pop[r]);
      end
      rr_q    <= rr_d;
      write_q <= write_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  // NOTE: FIFO storage is not reset; only entries inside the occupancy window are ever observed.
  always_ff @(posedge CLK) begin
    for (int r = 0; r < 2; r++) begin
      if (enq[r]) fifo_q[r][wptr_q[r]] <= in_ent[r];
    end
  end

  always_comb begin
    logic [PW-1:0] off;
    off    = '0;
    busy_d = '0;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < DEPTH; i++) begin
        off = PW'(i) - rptr_q[r];
        if (CW'(off) < cnt_q[r]) busy_d[fifo_q[r][i].addr] = 1'b1;
      end
    end
    if (write_q) busy_d[waddr_q] = 1'b1;
`ifdef REGWB_ZERO_REG_EN
    busy_d[0] = 1'b0;
`endif
  end

  assign ALU_READY = ready[0];
  assign MEM_READY = ready[1];
  assign WRITE     = write_q;
  assign INADDRESS = waddr_q;
  assign IN        = wdata_q;
  assign BUSY      = busy_d;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench for reg_write_arbiter: expected writes queued at drive time, compared on WRITE.
module tb_reg_write_arbiter;

  localparam int DEPTH  = 2;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;

  logic                   CLK, RESET;
  logic                   ALU_VALID, MEM_VALID;
  logic [ADDR_W-1:0]      ALU_ADDR, MEM_ADDR;
  logic [DATA_W-1:0]      ALU_DATA, MEM_DATA;
  logic                   ALU_READY, MEM_READY;
  logic                   WRITE;
  logic [ADDR_W-1:0]      INADDRESS;
  logic [DATA_W-1:0]      IN;
  logic [(2**ADDR_W)-1:0] BUSY;

  reg_write_arbiter #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .CLK(CLK), .RESET(RESET),
    .ALU_VALID(ALU_VALID), .ALU_ADDR(ALU_ADDR), .ALU_DATA(ALU_DATA), .ALU_READY(ALU_READY),
    .MEM_VALID(MEM_VALID), .MEM_ADDR(MEM_ADDR), .MEM_DATA(MEM_DATA), .MEM_READY(MEM_READY),
    .WRITE(WRITE), .INADDRESS(INADDRESS), .IN(IN), .BUSY(BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q [$];
  logic [31:0] mon_e;
  logic        mon_en;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ent(input int a, input int d);
    return {21'd0, a[ADDR_W-1:0], d[DATA_W-1:0]};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    ALU_VALID = 1'b0; ALU_ADDR = '0; ALU_DATA = '0;
    MEM_VALID = 1'b0; MEM_ADDR = '0; MEM_DATA = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    RESET = 1'b0;
    tick();
    tick();
    RESET = 1'b1;
    #1;
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 30 && (exp_q.size() != 0 || BUSY != '0); i++) tick();
    check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_busy_clear"}, 32'(BUSY), 32'd0);
  endtask

  // Scoreboard: every register-file write must match the oldest expected entry.
  always @(negedge CLK) begin
    if (RESET && WRITE && mon_en) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", ent(int'(INADDRESS), int'(IN)), 32'hDEAD_BEEF);
      end else begin
        mon_e = exp_q.pop_front();
        check("write_order", ent(int'(INADDRESS), int'(IN)), mon_e);
      end
    end
  end

  initial begin
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd;
    mon_en = 1'b1;
    RESET  = 1'b0;
    idle_inputs();
    tick();
    tick();
    check("rst_write", 32'(WRITE), 0);
    check("rst_inaddr", 32'(INADDRESS), 0);
    check("rst_in", 32'(IN), 0);
    check("rst_busy", 32'(BUSY), 0);
    check("rst_alu_ready", 32'(ALU_READY), 0);
    check("rst_mem_ready", 32'(MEM_READY), 0);
    RESET = 1'b1;
    #1;
    check("rel_alu_ready", 32'(ALU_READY), 1);
    check("rel_mem_ready", 32'(MEM_READY), 1);

    // Single ALU push: one-cycle WRITE one edge after the push, BUSY[2] spans both cycles.
    ALU_VALID = 1'b1; ALU_ADDR = 3'd2; ALU_DATA = 8'd95;
    exp_q.push_back(ent(2, 95));
    tick();
    ALU_VALID = 1'b0;
    check("single_k_write", 32'(WRITE), 0);
    check("single_k_busy2", 32'(BUSY[2]), 1);
    tick();
    check("single_k1_write", 32'(WRITE), 1);
    check("single_k1_addr", 32'(INADDRESS), 2);
    check("single_k1_data", 32'(IN), 95);
    check("single_k1_busy2", 32'(BUSY[2]), 1);
    tick();
    check("single_k2_write", 32'(WRITE), 0);
    check("single_k2_busy2", 32'(BUSY[2]), 0);
    check("single_hold_addr", 32'(INADDRESS), 2);
    check("single_hold_data", 32'(IN), 95);
    wait_drain("single");

    // Round robin across both sources on four back-to-back cycles.
    do_reset();
    ALU_VALID = 1'b1; ALU_ADDR = 3'd1; ALU_DATA = 8'd10;
    MEM_VALID = 1'b1; MEM_ADDR = 3'd4; MEM_DATA = 8'd20;
    exp_q.push_back(ent(1, 10)); exp_q.push_back(ent(4, 20));
    exp_q.push_back(ent(3, 11)); exp_q.push_back(ent(5, 21));
    tick();
    ALU_ADDR = 3'd3; ALU_DATA = 8'd11;
    MEM_ADDR = 3'd5; MEM_DATA = 8'd21;
    tick();
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      check("rr_back_to_back", 32'(WRITE), 1);
      tick();
    end
    check("rr_idle_after", 32'(WRITE), 0);
    wait_drain("rr");

    // Same-address heads: the load issues first regardless of pointer.
    do_reset();
    ALU_VALID = 1'b1; ALU_ADDR = 3'd6; ALU_DATA = 8'h11;
    MEM_VALID = 1'b1; MEM_ADDR = 3'd6; MEM_DATA = 8'h22;
    exp_q.push_back(ent(6, 8'h22)); exp_q.push_back(ent(6, 8'h11));
    tick();
    idle_inputs();
    check("tie_busy6", 32'(BUSY[6]), 1);
    wait_drain("tie");

    // Full ALU FIFO: same-address MEM stream holds priority, ALU stalls until it pops.
    do_reset();
    ALU_VALID = 1'b1; ALU_ADDR = 3'd7; ALU_DATA = 8'hA0;
    MEM_VALID = 1'b1; MEM_ADDR = 3'd7; MEM_DATA = 8'hB0;
    exp_q.push_back(ent(7, 8'hB0)); exp_q.push_back(ent(7, 8'hB1));
    exp_q.push_back(ent(7, 8'hB2)); exp_q.push_back(ent(7, 8'hB3));
    exp_q.push_back(ent(7, 8'hA0)); exp_q.push_back(ent(7, 8'hA1));
    exp_q.push_back(ent(7, 8'hA2));
    tick();
    check("full_alu_ready_1", 32'(ALU_READY), 1);
    ALU_DATA = 8'hA1; MEM_DATA = 8'hB1;
    tick();
    check("full_alu_ready_0a", 32'(ALU_READY), 0);
    ALU_DATA = 8'hA2; MEM_DATA = 8'hB2;
    tick();
    check("full_alu_ready_0b", 32'(ALU_READY), 0);
    MEM_DATA = 8'hB3;
    tick();
    check("full_alu_ready_0c", 32'(ALU_READY), 0);
    MEM_VALID = 1'b0;
    tick();
    check("full_alu_ready_0d", 32'(ALU_READY), 0);
    tick();
    check("full_alu_ready_back", 32'(ALU_READY), 1);
    tick();
    ALU_VALID = 1'b0;
    wait_drain("full");

    // Sustained single-source streams keep READY high and preserve FIFO order.
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 10; i++) begin
        ra = ADDR_W'($urandom_range(1, 7));
        rd = DATA_W'($urandom);
        if (s == 0) begin
          ALU_VALID = 1'b1; ALU_ADDR = ra; ALU_DATA = rd;
          check("stream_alu_ready", 32'(ALU_READY), 1);
        end else begin
          MEM_VALID = 1'b1; MEM_ADDR = ra; MEM_DATA = rd;
          check("stream_mem_ready", 32'(MEM_READY), 1);
        end
        exp_q.push_back(ent(int'(ra), int'(rd)));
        tick();
      end
      idle_inputs();
      wait_drain("stream");
    end

    // Register 0 behaviour.
    ALU_VALID = 1'b1; ALU_ADDR = 3'd0; ALU_DATA = 8'hFF;
    check("zero_ready", 32'(ALU_READY), 1);
`ifdef REGWB_ZERO_REG_EN
    tick();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      check("zero_no_write", 32'(WRITE), 0);
      check("zero_busy0", 32'(BUSY[0]), 0);
      tick();
    end
`else
    exp_q.push_back(ent(0, 8'hFF));
    tick();
    idle_inputs();
    check("zero_busy0", 32'(BUSY[0]), 1);
`endif
    wait_drain("zero");

    // Reset mid-drain: nothing queued before reset may appear afterwards.
    mon_en = 1'b0;
    ALU_VALID = 1'b1; ALU_ADDR = 3'd1; ALU_DATA = 8'h31;
    MEM_VALID = 1'b1; MEM_ADDR = 3'd3; MEM_DATA = 8'h33;
    tick();
    ALU_ADDR = 3'd2; ALU_DATA = 8'h32;
    MEM_ADDR = 3'd4; MEM_DATA = 8'h34;
    tick();
    idle_inputs();
    RESET = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("midrst_write", 32'(WRITE), 0);
      check("midrst_busy", 32'(BUSY), 0);
      check("midrst_alu_ready", 32'(ALU_READY), 0);
      check("midrst_mem_ready", 32'(MEM_READY), 0);
      tick();
    end
    RESET = 1'b1;
    #1;
    check("midrel_alu_ready", 32'(ALU_READY), 1);
    check("midrel_mem_ready", 32'(MEM_READY), 1);
    exp_q.delete();
    mon_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("post_rst_no_write", 32'(WRITE), 0);
      check("post_rst_busy", 32'(BUSY), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_write_arbiter.md
Name: reg_write_arbiter

Overview:
- Shares the register file's single write port between two writeback sources: ALU results (requester 0) and memory load data (requester 1).
- Each requester pushes through a valid/ready handshake into its own small FIFO.
- A round-robin arbiter drains the FIFOs into a registered write stage that drives the register file's IN/INADDRESS/WRITE inputs.
- Also publishes a per-register pending-write scoreboard, which the control unit uses for hazard stalls.

Parameters:
- DEPTH, 2, entries per requester FIFO (power of two, >=2)
- DATA_W, 8, write data width
- ADDR_W, 3, register address width; register count = 2**ADDR_W

Ports:
- CLK  in  1  clock; all state updates on posedge
- RESET  in  1  asynchronous, active-low reset (0 = reset)
- ALU_VALID  in  1  ALU writeback request
- ALU_ADDR  in  ADDR_W  ALU destination register
- ALU_DATA  in  DATA_W  ALU result
- ALU_READY  out  1  ALU FIFO can accept
- MEM_VALID  in  1  load writeback request
- MEM_ADDR  in  ADDR_W  load destination register
- MEM_DATA  in  DATA_W  load data
- MEM_READY  out  1  MEM FIFO can accept
- WRITE  out  1  register file write enable (registered)
- INADDRESS  out  ADDR_W  register file write address (registered)
- IN  out  DATA_W  register file write data (registered)
- BUSY  out  2**ADDR_W  bit r = 1 while any write to register r is queued or in the write stage

Behaviour:
- Reset (RESET=0, asynchronous):
  - Both FIFOs emptied; all pending writes discarded, including mid-operation.
  - WRITE=0, INADDRESS=0, IN=0, BUSY=0, ALU_READY=0, MEM_READY=0.
  - Round-robin pointer set to ALU.
- Release: READY outputs go high combinationally once RESET=1 and state is empty.
- Handshake:
  - Push occurs at posedge when VALID & READY.
  - READY = !full, computed from current occupancy only. A full FIFO refuses a push even if it pops in the same cycle.
  - Each source is FIFO-ordered.
- Arbitration, once per cycle, over FIFO heads only (not same-cycle pushes):
  - Neither FIFO non-empty: no pop, WRITE goes 0 next cycle.
  - One non-empty: pop that one.
  - Both non-empty: grant the requester indicated by the pointer, then point to the other.
  - Tie-break: if both heads target the same address, MEM head issues first regardless of pointer (load is older), and the pointer is then set to ALU.
- Write stage:
  - The popped entry is registered into INADDRESS/IN with WRITE=1 for exactly one cycle.
  - The register file commits it on the following posedge.
  - INADDRESS/IN hold their last values when WRITE=0.
- Latency:
  - Push at edge k into an empty, granted FIFO gives WRITE=1 during cycle k+1 to k+2; the register file commits at edge k+2.
- Throughput: one register write per cycle sustained; both FIFOs full drain in 2*DEPTH cycles, alternating sources.
- BUSY:
  - Combinational OR of the address decode over all valid FIFO entries plus the write-stage entry while WRITE=1.
  - Clears in the cycle after the last pending write to that register leaves the write stage.
- Simultaneous push and pop on the same FIFO (not full): both occur; occupancy unchanged.
- Pointers wrap modulo DEPTH.
- Full, empty and occupancy are tracked with DEPTH+1-state counters.

Optional Feature:
- Macro: REGWB_ZERO_REG_EN.
- Defined:
  - Register 0 is hardwired zero.
  - A handshake with ADDR=0 completes normally (READY rules unchanged) but nothing is enqueued.
  - BUSY[0] is constantly 0; WRITE is never asserted with INADDRESS=0.
- Undefined: address 0 is treated like any other register.

Test Plan:
- Reset mid-drain: fill both FIFOs, assert RESET=0 for 3 cycles → WRITE=0, BUSY=8'h00, READY=0 during reset; after release no stale writes appear.
- Single ALU push ADDR=2, DATA=8'd95 at edge k → WRITE=1, INADDRESS=2, IN=95 during cycle k+1 only; BUSY[2] high from k to k+2.
- Both FIFOs filled (ALU r1=10, r3=11; MEM r4=20, r5=21) → issue order r1, r4, r3, r5, alternating, on 4 consecutive cycles.
- Same-address tie: ALU head r6=8'h11 and MEM head r6=8'h22 both present → MEM write (22) issues first, then ALU (11).
- Full FIFO: DEPTH pushes with no drain (MEM priority held) → ALU_READY=0; a further ALU_VALID is not accepted until a pop occurs.
- With REGWB_ZERO_REG_EN: push ADDR=0, DATA=8'hFF → handshake completes, WRITE never asserted, BUSY[0]=0.
